// File: rtl/half_adder_pipe.sv
// Registered LANES-wide half adder with valid/ready handshake and a 2-entry skid buffer.
// Define HALF_ADDER_PARITY_EN to add a registered parity output that tracks the head result.
module half_adder_pipe #(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LANES-1:0] sum,
    output logic [LANES-1:0] carry,
    output logic             out_valid,
    input  logic             out_ready
`ifdef HALF_ADDER_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

`ifdef HALF_ADDER_PARITY_EN
    localparam int EW = 2 * LANES + 1;
`else
    localparam int EW = 2 * LANES;
`endif

    logic [1:0]       state_q, state_d;
    logic [EW-1:0]    main_q, main_d;
    logic [EW-1:0]    skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [LANES-1:0] new_sum;
    logic [LANES-1:0] new_carry;
    logic [EW-1:0]    new_entry;
    logic             in_xfer;
    logic             out_xfer;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign new_sum[gi]   = a[gi] ^ b[gi];
        assign new_carry[gi] = a[gi] & b[gi];
    end

    // Entry layout: {[parity,] carry, sum}
`ifdef HALF_ADDER_PARITY_EN
    assign new_entry = {^{new_carry, new_sum}, new_carry, new_sum};
`else
    assign new_entry = {new_carry, new_sum};
`endif

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = new_entry;
                end else if (in_xfer) begin
                    skid_d  = new_entry;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Handshake flags are registered from the next state so out_ready never reaches in_ready combinationally.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = main_q[LANES-1:0];
    assign carry     = main_q[2*LANES-1:LANES];
`ifdef HALF_ADDER_PARITY_EN
    assign parity    = main_q[2*LANES];
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Self-checking bench for half_adder_pipe (LANES=8): directed vectors plus a FIFO scoreboard.
module tb_half_adder_pipe;

    localparam int LANES = 8;

    logic             clk;
    logic             rst_n;
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] sum;
    logic [LANES-1:0] carry;
    logic             out_valid;
    logic             out_ready;
`ifdef HALF_ADDER_PARITY_EN
    logic             parity;
`endif

    half_adder_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef HALF_ADDER_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [16:0]      exp_q[$];
    logic             stall_pending = 1'b0;
    logic [LANES-1:0] held_sum;
    logic [LANES-1:0] held_carry;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the scoreboard, then advance past the edge.
    task automatic cycle(input logic v, input logic [LANES-1:0] av, input logic [LANES-1:0] bv,
                         input logic ordy);
        logic        in_x;
        logic        out_x;
        logic [16:0] e;
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        if (stall_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, held_sum);
            check("hold_carry", carry, held_carry);
        end
        check("in_ready", in_ready, exp_q.size() < 2);
        check("out_valid", out_valid, exp_q.size() != 0);
        in_x  = v && in_ready;
        out_x = out_valid && ordy;
        if (out_x && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_sum", sum, e[7:0]);
            check("sb_carry", carry, e[15:8]);
`ifdef HALF_ADDER_PARITY_EN
            check("sb_parity", parity, e[16]);
`endif
        end
        stall_pending = out_valid && !ordy;
        held_sum      = sum;
        held_carry    = carry;
        if (in_x) exp_q.push_back({^{av & bv, av ^ bv}, av & bv, av ^ bv});
        @(posedge clk);
        #1;
    endtask

    logic [LANES-1:0] tt_a[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
    logic [LANES-1:0] tt_b[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    logic [LANES-1:0] tt_s[4] = '{8'd0, 8'd1, 8'd1, 8'd0};
    logic [LANES-1:0] tt_c[4] = '{8'd0, 8'd0, 8'd0, 8'd1};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        rst_n = 1'b1;

        // Truth table on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, tt_a[i], tt_b[i], 1'b1);
            check("tt_valid", out_valid, 1);
            check("tt_sum", sum, tt_s[i]);
            check("tt_carry", carry, tt_c[i]);
        end
        cycle(1'b0, '0, '0, 1'b1);

        // Backpressure
        cycle(1'b1, 8'b1010, 8'b0110, 1'b0);
        cycle(1'b1, 8'b1111, 8'b0001, 1'b0);
        check("bp_in_ready", in_ready, 0);
        check("bp_sum0", sum, 8'b1100);
        check("bp_carry0", carry, 8'b0010);
        cycle(1'b0, '0, '0, 1'b1);
        check("bp_sum1", sum, 8'b1110);
        check("bp_carry1", carry, 8'b0001);
        cycle(1'b0, '0, '0, 1'b1);
        check("bp_drained", out_valid, 0);

        // Full throughput
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, LANES'($urandom), LANES'($urandom), 1'b1);
            check("tp_no_bubble", out_valid, 1);
        end
        cycle(1'b0, '0, '0, 1'b1);

        // Random stalls
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), LANES'($urandom), LANES'($urandom),
                  1'($urandom_range(0, 1)));
        end
        repeat (4) cycle(1'b0, '0, '0, 1'b1);
        check("drain_empty", exp_q.size(), 0);

`ifdef HALF_ADDER_PARITY_EN
        cycle(1'b1, 8'b11, 8'b01, 1'b1);
        check("par0_sum", sum, 8'b10);
        check("par0_carry", carry, 8'b01);
        check("par0_parity", parity, 0);
        cycle(1'b1, 8'b10, 8'b00, 1'b1);
        check("par1_sum", sum, 8'b10);
        check("par1_carry", carry, 8'b00);
        check("par1_parity", parity, 1);
        cycle(1'b0, '0, '0, 1'b1);
`endif

        // Mid-operation reset with buffer full
        cycle(1'b1, 8'h03, 8'h05, 1'b0);
        cycle(1'b1, 8'h07, 8'h01, 1'b0);
        check("full_in_ready", in_ready, 0);
        check("full_sum", sum, 8'h06);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_sum", sum, 0);
        check("mrst_carry", carry, 0);
`ifdef HALF_ADDER_PARITY_EN
        check("mrst_parity", parity, 0);
`endif
        exp_q.delete();
        stall_pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'd1, 8'd1, 1'b1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_carry", carry, 8'd1);
        check("post_rst_sum", sum, 8'd0);
        cycle(1'b0, '0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
